arch_map_table_param: RTL and testbench

- Architectural Map Table (AMT) for the retire stage, parametrised in commit width, logical register count, physical tag width and recovery width.
- Records the committed logical-to-physical mapping and releases displaced physical tags to the speculative free list.
- On recovery, it streams the full AMT to the RMT in RECOVER_WIDTH-entry groups, with a busy/done handshake, and handles a partial final group correctly.
- Sits between the Active List (commit side) and the RMT/free list (recovery/release side).

---
 rtl/arch_map_table_param_pkg.sv | 18 +
 rtl/arch_map_table_param_amt_ram_multiport.sv | 37 +++
 rtl/arch_map_table_param.sv | 151 +++++++++++++++
 tb/tb_arch_map_table_param.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/arch_map_table_param_pkg.sv
// Shared defaults, FSM encoding and packed-slice helper for the architectural map table.
// Optional feature macro: AMT_ZERO_REG_EN (logical 0 hardwired to physical 0).
`ifndef ARCH_MAP_TABLE_PARAM_PKG_SV
`define ARCH_MAP_TABLE_PARAM_PKG_SV

`define AMT_SLICE(vec, idx, w) vec[(idx)*(w) +: (w)]

package arch_map_table_param_pkg;
  localparam int LOG_W_DEF = 6;
  localparam int PHY_W_DEF = 7;

  typedef enum logic {
    IDLE    = 1'b0,
    RECOVER = 1'b1
  } amtState_t;
endpackage

`endif

// File: rtl/arch_map_table_param_amt_ram_multiport.sv
// AMT storage: flop array with highest-index-wins write ports, async comb read
// ports, and asynchronous reset to the identity map.
module amt_ram_multiport #(
  parameter int NUM_ENTRIES = 34,
  parameter int LOG_W       = 6,
  parameter int PHY_W       = 7,
  parameter int NUM_WR      = 4,
  parameter int NUM_RD      = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_WR-1:0]             we,
  input  logic [NUM_WR-1:0][LOG_W-1:0]  waddr,
  input  logic [NUM_WR-1:0][PHY_W-1:0]  wdata,
  input  logic [NUM_RD-1:0][LOG_W-1:0]  raddr,
  output logic [NUM_RD-1:0][PHY_W-1:0]  rdata
);
  logic [PHY_W-1:0] mem [NUM_ENTRIES];

  for (genvar e = 0; e < NUM_ENTRIES; e++) begin : g_ent
    // Later ports overwrite earlier ones, so the youngest slot wins.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) mem[e] <= PHY_W'(e);
      else begin
        for (int k = 0; k < NUM_WR; k++)
          if (we[k] && waddr[k] == LOG_W'(e)) mem[e] <= wdata[k];
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int r = 0; r < NUM_RD; r++)
      for (int e = 0; e < NUM_ENTRIES; e++)
        if (raddr[r] == LOG_W'(e)) rdata[r] = mem[e];
  end
endmodule

// File: rtl/arch_map_table_param.sv
// Retire-stage architectural map table: commits mappings, releases displaced tags,
// and streams the table to the RMT on recovery. Optional macro: AMT_ZERO_REG_EN.
module arch_map_table_param
  import arch_map_table_param_pkg::*;
#(
  parameter int COMMIT_WIDTH  = 4,
  parameter int NUM_LOG_REGS  = 34,
  parameter int LOG_W         = LOG_W_DEF,
  parameter int PHY_W         = PHY_W_DEF,
  parameter int RECOVER_WIDTH = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [COMMIT_WIDTH-1:0]          commitValid_i,
  input  logic [COMMIT_WIDTH*LOG_W-1:0]    commitLogDest_i,
  input  logic [COMMIT_WIDTH*PHY_W-1:0]    commitPhyDest_i,
  input  logic                             recoverFlag_i,
  output logic [COMMIT_WIDTH-1:0]          releasedValid_o,
  output logic [COMMIT_WIDTH*PHY_W-1:0]    releasedPhyMap_o,
  output logic [RECOVER_WIDTH-1:0]         recoverValid_o,
  output logic [RECOVER_WIDTH*LOG_W-1:0]   recoverLogDest_o,
  output logic [RECOVER_WIDTH*PHY_W-1:0]   recoverPhyDest_o,
  output logic                             recoverBusy_o,
  output logic                             recoverDone_o
);
  localparam int CNT_W = LOG_W + 1;
  localparam int NRD   = COMMIT_WIDTH + RECOVER_WIDTH;

  amtState_t state, stateNxt;
  logic [CNT_W-1:0] cnt, cntNxt;
  logic lastGroup;

  logic [COMMIT_WIDTH-1:0][LOG_W-1:0]  logDest;
  logic [COMMIT_WIDTH-1:0][PHY_W-1:0]  phyDest, relRd, relTag;
  logic [COMMIT_WIDTH-1:0]             zeroDest, shadowed, commitEn, wrEn;
  logic [RECOVER_WIDTH-1:0][LOG_W-1:0] recAddr;
  logic [RECOVER_WIDTH-1:0][PHY_W-1:0] recRd;
  logic [RECOVER_WIDTH-1:0][31:0]      recIdx;
  logic [RECOVER_WIDTH-1:0]            laneVld;
  logic [NRD-1:0][LOG_W-1:0]           rdAddr;
  logic [NRD-1:0][PHY_W-1:0]           rdData;

  for (genvar k = 0; k < COMMIT_WIDTH; k++) begin : g_slot
    assign logDest[k] = `AMT_SLICE(commitLogDest_i, k, LOG_W);
    assign phyDest[k] = `AMT_SLICE(commitPhyDest_i, k, PHY_W);
`ifdef AMT_ZERO_REG_EN
    assign zeroDest[k] = (logDest[k] == '0);
`else
    assign zeroDest[k] = 1'b0;
`endif
    // A shadowed slot never reached the table, so it frees its own tag.
    assign relTag[k] = shadowed[k] ? phyDest[k] : relRd[k];
  end

  always_comb begin
    shadowed = '0;
    for (int k = 0; k < COMMIT_WIDTH; k++)
      for (int j = k + 1; j < COMMIT_WIDTH; j++)
        if (commitValid_i[j] && logDest[j] == logDest[k]) shadowed[k] = 1'b1;
  end

  assign commitEn = (state == IDLE) ? (commitValid_i & ~zeroDest) : '0;
  assign wrEn     = commitEn & ~shadowed;

  for (genvar r = 0; r < RECOVER_WIDTH; r++) begin : g_lane
    assign recIdx[r]  = 32'(cnt) + 32'(r);
    assign recAddr[r] = recIdx[r][LOG_W-1:0];
    assign laneVld[r] = (state == RECOVER) && (recIdx[r] < 32'(NUM_LOG_REGS));
    assign recoverValid_o[r] = laneVld[r];
    assign `AMT_SLICE(recoverLogDest_o, r, LOG_W) = laneVld[r] ? recAddr[r] : '0;
    assign `AMT_SLICE(recoverPhyDest_o, r, PHY_W) = laneVld[r] ? recRd[r] : '0;
  end

  assign rdAddr = {recAddr, logDest};
  assign relRd  = rdData[COMMIT_WIDTH-1:0];
  assign recRd  = rdData[NRD-1:COMMIT_WIDTH];

  amt_ram_multiport #(
    .NUM_ENTRIES (NUM_LOG_REGS),
    .LOG_W       (LOG_W),
    .PHY_W       (PHY_W),
    .NUM_WR      (COMMIT_WIDTH),
    .NUM_RD      (NRD)
  ) uRam (
    .clk   (clk),
    .reset (reset),
    .we    (wrEn),
    .waddr (logDest),
    .wdata (phyDest),
    .raddr (rdAddr),
    .rdata (rdData)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      releasedValid_o  <= '0;
      releasedPhyMap_o <= '0;
    end else begin
      releasedValid_o <= commitEn;
      for (int k = 0; k < COMMIT_WIDTH; k++)
        `AMT_SLICE(releasedPhyMap_o, k, PHY_W) <= commitEn[k] ? relTag[k] : '0;
    end
  end

  // Walk outputs come straight from the state/counter/table flops, so the
  // commits of the flag cycle are already in the table when group 0 shows.
  assign lastGroup     = (32'(cnt) + 32'(RECOVER_WIDTH)) >= 32'(NUM_LOG_REGS);
  assign recoverBusy_o = (state == RECOVER);
  assign recoverDone_o = (state == RECOVER) && lastGroup;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNxt;
      cnt   <= cntNxt;
    end
  end

  always_comb begin
    stateNxt = state;
    cntNxt   = cnt;
    case (state)
      IDLE:
        if (recoverFlag_i) begin
          stateNxt = RECOVER;
          cntNxt   = '0;
        end
      RECOVER:
        if (lastGroup) begin
          stateNxt = IDLE;
          cntNxt   = '0;
        end else begin
          cntNxt = cnt + CNT_W'(RECOVER_WIDTH);
        end
      default: begin
        stateNxt = IDLE;
        cntNxt   = '0;
      end
    endcase
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (reset && state == RECOVER)
      assert (commitValid_i == '0)
      else $warning("commit during recovery ignored");
  end
`endif
endmodule

// File: tb/tb_arch_map_table_param.sv
// Scoreboard bench for arch_map_table_param: directed commits and recovery walks.
module tb_arch_map_table_param;
  localparam int CW = 4, NL = 34, LW = 6, PW = 7, RW = 4;
  localparam int NG = (NL + RW - 1) / RW;

  logic clk = 1'b0, reset = 1'b0;
  logic [CW-1:0]    commitValid_i = '0;
  logic [CW*LW-1:0] commitLogDest_i = '0;
  logic [CW*PW-1:0] commitPhyDest_i = '0;
  logic             recoverFlag_i = 1'b0;
  logic [CW-1:0]    releasedValid_o;
  logic [CW*PW-1:0] releasedPhyMap_o;
  logic [RW-1:0]    recoverValid_o;
  logic [RW*LW-1:0] recoverLogDest_o;
  logic [RW*PW-1:0] recoverPhyDest_o;
  logic             recoverBusy_o, recoverDone_o;

  arch_map_table_param dut (
    .clk(clk), .reset(reset),
    .commitValid_i(commitValid_i), .commitLogDest_i(commitLogDest_i),
    .commitPhyDest_i(commitPhyDest_i), .recoverFlag_i(recoverFlag_i),
    .releasedValid_o(releasedValid_o), .releasedPhyMap_o(releasedPhyMap_o),
    .recoverValid_o(recoverValid_o), .recoverLogDest_o(recoverLogDest_o),
    .recoverPhyDest_o(recoverPhyDest_o), .recoverBusy_o(recoverBusy_o),
    .recoverDone_o(recoverDone_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [CW-1:0] v; logic [CW*PW-1:0] p; } relExp_t;
  typedef struct { logic [RW-1:0] v; logic [RW*LW-1:0] l; logic [RW*PW-1:0] p; logic done; } recExp_t;

  relExp_t relQ[$];
  recExp_t recQ[$];
  int nCmp = 0, nBad = 0;
  logic [PW-1:0] model [NL];

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: pops expectations whenever the DUT presents a release or a recovery group.
  always @(negedge clk) begin
    if (reset) begin
      if (|releasedValid_o) begin
        relExp_t e;
        if (relQ.size() == 0) chk("unexpectedRelease", 64'(releasedValid_o), 64'd0);
        else begin
          e = relQ.pop_front();
          chk("relValid", 64'(releasedValid_o), 64'(e.v));
          chk("relPhy", 64'(releasedPhyMap_o), 64'(e.p));
        end
      end
      if (recoverBusy_o) begin
        recExp_t g;
        if (recQ.size() == 0) chk("extraRecoverCycle", 64'(recoverBusy_o), 64'd0);
        else begin
          g = recQ.pop_front();
          chk("recValid", 64'(recoverValid_o), 64'(g.v));
          chk("recLog", 64'(recoverLogDest_o), 64'(g.l));
          chk("recPhy", 64'(recoverPhyDest_o), 64'(g.p));
          chk("recDone", 64'(recoverDone_o), 64'(g.done));
        end
      end else if (|recoverValid_o || recoverDone_o)
        chk("recOutWhileIdle", {59'd0, recoverValid_o, recoverDone_o}, 64'd0);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic commit(input logic [CW-1:0] v, input logic [CW*LW-1:0] l,
                        input logic [CW*PW-1:0] p, input logic [CW-1:0] ev,
                        input logic [CW*PW-1:0] ep);
    relExp_t e;
    commitValid_i = v; commitLogDest_i = l; commitPhyDest_i = p;
    if (ev != '0) begin e.v = ev; e.p = ep; relQ.push_back(e); end
    tick();
    commitValid_i = '0;
  endtask

  task automatic pushWalk();
    for (int g = 0; g < NG; g++) begin
      recExp_t e;
      e.v = '0; e.l = '0; e.p = '0; e.done = (g == NG - 1);
      for (int r = 0; r < RW; r++)
        if (g * RW + r < NL) begin
          e.v[r] = 1'b1;
          e.l[r*LW +: LW] = LW'(g * RW + r);
          e.p[r*PW +: PW] = model[g * RW + r];
        end
      recQ.push_back(e);
    end
  endtask

  task automatic startRecover();
    recoverFlag_i = 1'b1;
    pushWalk();
    tick();
    recoverFlag_i = 1'b0;
  endtask

  task automatic waitWalk();
    int n = 0;
    while (recQ.size() != 0 && n < 40) begin tick(); n++; end
    chk("walkTimeout", 64'(n >= 40), 64'd0);
    tick();
    chk("busyAfterWalk", 64'(recoverBusy_o), 64'd0);
  endtask

  task automatic resetModel();
    for (int i = 0; i < NL; i++) model[i] = PW'(i);
  endtask

  initial begin
    resetModel();
    #12;
    chk("rstRelValid", 64'(releasedValid_o), 64'd0);
    chk("rstRelPhy", 64'(releasedPhyMap_o), 64'd0);
    chk("rstRecValid", 64'(recoverValid_o), 64'd0);
    chk("rstRecLog", 64'(recoverLogDest_o), 64'd0);
    chk("rstRecPhy", 64'(recoverPhyDest_o), 64'd0);
    chk("rstBusy", 64'(recoverBusy_o), 64'd0);
    chk("rstDone", 64'(recoverDone_o), 64'd0);
    tick();
    reset = 1'b1;
    tick();

    // single commit: log3 -> phy40 releases 3
    commit(4'b0001, {6'd0, 6'd0, 6'd0, 6'd3}, {7'd0, 7'd0, 7'd0, 7'd40},
           4'b0001, {7'd0, 7'd0, 7'd0, 7'd3});
    model[3] = 7'd40;
    // duplicates: slot0 shadowed (releases own 41), slot2 releases old 5
    commit(4'b0101, {6'd0, 6'd5, 6'd0, 6'd5}, {7'd0, 7'd42, 7'd0, 7'd41},
           4'b0101, {7'd0, 7'd5, 7'd0, 7'd41});
    model[5] = 7'd42;
    // four distinct slots, slot3 displaces the earlier 40
    commit(4'b1111, {6'd3, 6'd12, 6'd11, 6'd10}, {7'd73, 7'd72, 7'd71, 7'd70},
           4'b1111, {7'd40, 7'd12, 7'd11, 7'd10});
    model[10] = 7'd70; model[11] = 7'd71; model[12] = 7'd72; model[3] = 7'd73;
    tick();

    // full recovery, 9 groups, last with 2 lanes
    startRecover();
    waitWalk();

    // commit and a second flag during the walk are both ignored
    startRecover();
    commitValid_i = 4'b0010; commitLogDest_i = {6'd0, 6'd0, 6'd7, 6'd0};
    commitPhyDest_i = {7'd0, 7'd0, 7'd50, 7'd0}; recoverFlag_i = 1'b1;
    tick();
    commitValid_i = '0; recoverFlag_i = 1'b0;
    waitWalk();

    // reset while group 3 is on the bus
    startRecover();
    for (int n = 0; n < 20 && recQ.size() > 6; n++) tick();
    chk("group3Shown", 64'(recoverValid_o), 64'hf);
    chk("group3Log", 64'(recoverLogDest_o), 64'({6'd15, 6'd14, 6'd13, 6'd12}));
    reset = 1'b0;
    #1;
    chk("midRstBusy", 64'(recoverBusy_o), 64'd0);
    chk("midRstValid", 64'(recoverValid_o), 64'd0);
    chk("midRstPhy", 64'(recoverPhyDest_o), 64'd0);
    chk("midRstDone", 64'(recoverDone_o), 64'd0);
    recQ.delete();
    resetModel();
    tick();
    reset = 1'b1;
    tick();
    startRecover();
    waitWalk();

    // logical 0 behaviour
`ifdef AMT_ZERO_REG_EN
    commit(4'b0001, {6'd0, 6'd0, 6'd0, 6'd0}, {7'd0, 7'd0, 7'd0, 7'd60},
           4'b0000, '0);
`else
    commit(4'b0001, {6'd0, 6'd0, 6'd0, 6'd0}, {7'd0, 7'd0, 7'd0, 7'd60},
           4'b0001, {7'd0, 7'd0, 7'd0, 7'd0});
    model[0] = 7'd60;
`endif
    tick();
    startRecover();
    waitWalk();

    tick();
    chk("relQEmpty", 64'(relQ.size()), 64'd0);
    chk("recQEmpty", 64'(recQ.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
